debounce_bank: RTL and testbench
================================

# debounce_bank

Parametrised multi-channel push-button/switch conditioner that sits between raw board inputs and the control FSMs. Each channel has:
- an input synchroniser;
- a counter-based stability filter, so a level must be held for a programmable number of cycles;
- a registered debounced level;
- single-cycle rise, fall and long-press pulses.

This block replaces the fixed shift-register edge detector with a configurable, glitch-rejecting filter that covers both edge directions.

## Interface
Parameters:
- N_CH, 4, number of independent channels
- SYNC_STAGES, 2, synchroniser depth (legal ≥ 2)
- STABLE_CYCLES, 8, consecutive differing samples required before the level flips (legal ≥ 1)
- LONG_CYCLES, 32, cycles the level must stay high before long_o fires; 0 disables long-press

Ports:
- clk  in  1  system clock; all logic on rising edge
- clear_n  in  1  asynchronous active-low reset
- btn_i  in  N_CH  raw asynchronous inputs
- level_o  out  N_CH  debounced level per channel
- rise_o  out  N_CH  one-cycle pulse when level_o goes 0→1
- fall_o  out  N_CH  one-cycle pulse when level_o goes 1→0
- long_o  out  N_CH  one-cycle pulse per press once held LONG_CYCLES

## Operation
- Reset (clear_n low, asynchronous): all synchroniser flops, counters, level_o, rise_o, fall_o and long_o go to 0 immediately. They stay 0 while clear_n is low.
- Synchroniser: btn_i[c] passes through SYNC_STAGES flops; the last stage is s[c].
- Stability counter cnt[c], width $clog2(STABLE_CYCLES):
  - If s[c] == level_o[c]: cnt ← 0.
  - Else if cnt == STABLE_CYCLES−1: level_o ← s[c], cnt ← 0, and rise_o or fall_o (per new value) is 1 for exactly that cycle.
  - Else: cnt ← cnt+1.
- Glitch rejection: any return of s[c] to level_o[c] before the count completes clears cnt. There is no partial credit; the next attempt restarts from 0.
- STABLE_CYCLES = 1: level_o follows s with one register delay; the pulses still work.
- Long-press counter hold[c], saturating, width $clog2(LONG_CYCLES+1):
  - Cleared when level_o[c] is 0.
  - Increments each cycle while level_o[c] is 1.
  - long_o[c] pulses for one cycle when hold reaches LONG_CYCLES, then hold saturates, so there is no repeat until release.
- Channels are fully independent; simultaneous events on multiple channels are all reported in the same cycle.
- rise_o and fall_o are mutually exclusive per channel. long_o never coincides with rise_o on the same channel when LONG_CYCLES ≥ 1.

## Timing
- All outputs are registered; no combinational path from btn_i to any output.
- Latency: btn_i changes before edge k and then stays stable. level_o and the edge pulse update at edge k + SYNC_STAGES + STABLE_CYCLES − 1, i.e. SYNC_STAGES+STABLE_CYCLES edges counting k as edge 1. With defaults that is 10 edges.
- long_o asserts LONG_CYCLES edges after the edge that raised rise_o.
- Reset mid-count: counters clear asynchronously.
- Reset release with btn_i already high: behaves as a fresh 0→1 transition, so rise_o fires after the full latency.
- Reset release is assumed synchronised externally to clk.
- Minimum detectable pulse width on btn_i: STABLE_CYCLES cycles (plus metastability margin). Shorter pulses produce no output.

## Structure
- Shared package debounce_pkg holds:
  - a width helper function (clog2 with minimum 1);
  - default parameter constants DB_SYNC_STAGES, DB_STABLE_CYCLES, DB_LONG_CYCLES.
- Sub-module debounce_channel implements one channel: synchroniser, stability counter, level register, pulse generation and long-press counter.
- debounce_bank instantiates N_CH copies in a generate loop and concatenates the outputs.
- Parameter checks (SYNC_STAGES ≥ 2, STABLE_CYCLES ≥ 1) as elaboration-time assertions.

## Test plan
All scenarios use defaults (N_CH=4, SYNC=2, STABLE=8, LONG=32).
- Reset: hold clear_n low with btn_i=4'hF → all outputs 0. Release → rise_o=4'hF for one cycle at edge 10, level_o=4'hF thereafter.
- Clean press on ch0: btn_i[0] 0→1 before edge k → rise_o[0] high only at edge k+9, level_o[0]=1 from k+9. Then release → fall_o[0] high one cycle at release+9.
- Glitch: btn_i[1] high for 7 cycles then low → level_o, rise_o and fall_o stay 0. High for 8 cycles → exactly one rise, then one fall 8 cycles after it drops (plus sync delay).
- Bounce: ch2 toggles every 3 cycles for 40 cycles, then stays high → exactly one rise_o, 10 edges after the final toggle; no fall_o.
- Long press: ch3 held high 100 cycles → rise_o[3] once, long_o[3] exactly once 32 edges after rise, no repeat. Release and re-press → long_o fires again.
- Concurrency and reset mid-count: ch0 and ch1 change on the same edge → rise pulses on the same cycle. Assert clear_n at cnt=5 → all zero immediately, no pulse on release until the full 10-edge latency elapses.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce bank.
package debounce_pkg;

  localparam int DB_SYNC_STAGES   = 2;
  localparam int DB_STABLE_CYCLES = 8;
  localparam int DB_LONG_CYCLES   = 32;

  function automatic int db_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One channel: synchroniser, stability filter,
// level register, edge pulses and long-press detector.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DB_SYNC_STAGES,
  parameter int STABLE_CYCLES = DB_STABLE_CYCLES,
  parameter int LONG_CYCLES   = DB_LONG_CYCLES
) (
  input  logic clk,
  input  logic clear_n,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o
);

  localparam int CW = db_width(STABLE_CYCLES);
  localparam int HW = db_width(LONG_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(STABLE_CYCLES - 1);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
      $error("STABLE_CYCLES must be >= 1");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_long;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_i};
    end
  end

  // Any sample matching the current level wipes progress.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt   <= '0;
        r_level <= w_s;
        r_rise  <= w_s;
        r_fall  <= ~w_s;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  generate
    if (LONG_CYCLES > 0) begin : g_long
      localparam logic [HW-1:0] HOLD_MAX =
        HW'(LONG_CYCLES);
      logic [HW-1:0] r_hold;

      always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
          r_hold <= '0;
          r_long <= 1'b0;
        end else if (!r_level) begin
          r_hold <= '0;
          r_long <= 1'b0;
        end else if (r_hold != HOLD_MAX) begin
          r_hold <= r_hold + 1'b1;
          r_long <= (r_hold == HOLD_MAX - 1'b1);
        end else begin
          r_long <= 1'b0;
        end
      end
    end else begin : g_no_long
      assign r_long = 1'b0;
    end
  endgenerate

  assign level_o = r_level;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;
  assign long_o  = r_long;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels with
// concatenated level and pulse outputs.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = DB_SYNC_STAGES,
  parameter int STABLE_CYCLES = DB_STABLE_CYCLES,
  parameter int LONG_CYCLES   = DB_LONG_CYCLES
) (
  input  logic            clk,
  input  logic            clear_n,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic [N_CH-1:0] long_o
);

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      debounce_channel #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .LONG_CYCLES  (LONG_CYCLES)
      ) u_ch (
        .clk    (clk),
        .clear_n(clear_n),
        .btn_i  (btn_i[c]),
        .level_o(level_o[c]),
        .rise_o (rise_o[c]),
        .fall_o (fall_o[c]),
        .long_o (long_o[c])
      );
    end
  endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank with default parameters.
module tb_debounce_bank;

  localparam int LAT  = 10;
  localparam int LONG = 32;

  typedef struct {
    int         cyc;
    logic [3:0] r;
    logic [3:0] f;
    logic [3:0] l;
  } ev_t;

  logic       clk = 1'b0;
  logic       clear_n;
  logic [3:0] btn_i;
  logic [3:0] level_o;
  logic [3:0] rise_o;
  logic [3:0] fall_o;
  logic [3:0] long_o;

  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  ev_t q[$];

  debounce_bank dut (
    .clk    (clk),
    .clear_n(clear_n),
    .btn_i  (btn_i),
    .level_o(level_o),
    .rise_o (rise_o),
    .fall_o (fall_o),
    .long_o (long_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int dly, input logic [3:0] r,
                           input logic [3:0] f, input logic [3:0] l);
    ev_t e;
    e.cyc = cyc + dly;
    e.r = r;
    e.f = f;
    e.l = l;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check4(input string name, input logic [3:0] act,
                        input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: every cycle with any pulse must match the queue head.
  always @(negedge clk) begin
    if ((rise_o | fall_o | long_o) != 4'h0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: cyc=%0d rise=%h fall=%h long=%h required none",
                 cyc, rise_o, fall_o, long_o);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.r !== rise_o || e.f !== fall_o
            || e.l !== long_o) begin
          errors++;
          $display("FAIL pulse: got cyc=%0d r=%h f=%h l=%h required cyc=%0d r=%h f=%h l=%h",
                   cyc, rise_o, fall_o, long_o, e.cyc, e.r, e.f, e.l);
        end
      end
    end
  end

  initial begin
    clear_n = 1'b0;
    btn_i   = 4'hF;

    // Reset with all buttons high, then release
    step(5);
    check4("reset_level", level_o, 4'h0);
    check4("reset_pulses", rise_o | fall_o | long_o, 4'h0);
    clear_n = 1'b1;
    expect_ev(LAT, 4'hF, 4'h0, 4'h0);
    expect_ev(LAT + LONG, 4'h0, 4'h0, 4'hF);
    step(LAT - 1);
    check4("pre_rise_level", level_o, 4'h0);
    step(2);
    check4("post_rise_level", level_o, 4'hF);
    step(39);
    btn_i = 4'h0;
    expect_ev(LAT, 4'h0, 4'hF, 4'h0);
    step(20);
    check4("all_released", level_o, 4'h0);

    // Clean press on ch0
    btn_i = 4'b0001;
    expect_ev(LAT, 4'b0001, 4'h0, 4'h0);
    step(15);
    check4("ch0_level", level_o, 4'b0001);
    step(5);
    btn_i = 4'b0000;
    expect_ev(LAT, 4'h0, 4'b0001, 4'h0);
    step(15);

    // Glitch: 7 cycles rejected
    btn_i = 4'b0010;
    step(7);
    btn_i = 4'b0000;
    step(15);
    check4("glitch7_level", level_o, 4'h0);

    // 8 cycles accepted
    btn_i = 4'b0010;
    expect_ev(LAT, 4'b0010, 4'h0, 4'h0);
    step(8);
    btn_i = 4'b0000;
    expect_ev(LAT, 4'h0, 4'b0010, 4'h0);
    step(15);
    check4("pulse8_level", level_o, 4'h0);

    // Bounce on ch2, then settle high
    for (int i = 0; i < 14; i++) begin
      btn_i[2] = ~i[0];
      step(3);
    end
    check4("bounce_level", level_o, 4'h0);
    btn_i[2] = 1'b1;
    expect_ev(LAT, 4'b0100, 4'h0, 4'h0);
    step(20);
    check4("bounce_settled", level_o, 4'b0100);
    btn_i[2] = 1'b0;
    expect_ev(LAT, 4'h0, 4'b0100, 4'h0);
    step(15);

    // Long press on ch3, twice
    for (int p = 0; p < 2; p++) begin
      btn_i[3] = 1'b1;
      expect_ev(LAT, 4'b1000, 4'h0, 4'h0);
      expect_ev(LAT + LONG, 4'h0, 4'h0, 4'b1000);
      step(100);
      check4("long_level", level_o, 4'b1000);
      btn_i[3] = 1'b0;
      expect_ev(LAT, 4'h0, 4'b1000, 4'h0);
      step(15);
    end

    // Concurrent press on ch0 and ch1
    btn_i = 4'b0011;
    expect_ev(LAT, 4'b0011, 4'h0, 4'h0);
    step(15);
    check4("conc_level", level_o, 4'b0011);
    btn_i = 4'b0000;
    expect_ev(LAT, 4'h0, 4'b0011, 4'h0);
    step(15);

    // Reset mid-count on ch0 while ch3 is already high
    btn_i = 4'b1000;
    expect_ev(LAT, 4'b1000, 4'h0, 4'h0);
    step(15);
    btn_i = 4'b1001;
    step(7);
    clear_n = 1'b0;
    #1;
    check4("async_clear_level", level_o, 4'h0);
    step(3);
    check4("held_reset_level", level_o, 4'h0);
    clear_n = 1'b1;
    expect_ev(LAT, 4'b1001, 4'h0, 4'h0);
    expect_ev(LAT + LONG, 4'h0, 4'h0, 4'b1001);
    step(LAT - 1);
    check4("rst_pre_rise", level_o, 4'h0);
    step(40);
    check4("rst_post_long", level_o, 4'b1001);
    btn_i = 4'b0000;
    expect_ev(LAT, 4'h0, 4'b1001, 4'h0);

    // Bounded drain of the scoreboard
    for (int t = 0; t < 60 && q.size() != 0; t++) step(1);
    step(5);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending events required 0", q.size());
    end
    check4("final_level", level_o, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
